// File: rtl/reaction_stimulus_if.sv
// Pulse/status bundle between the reaction-game controller and its user.
// There is no valid/ready handshake here: start, stop and clear are
// single-cycle, already-debounced pulses that are acted on in the cycle they
// are sampled. Every output is a register, so a consumer may sample it on
// any clock edge without worrying about combinational glitches.
interface reaction_stimulus_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        stim_led;
  logic        go;
  logic        halt;
  logic        early;
  logic        timeout;
  logic [2:0]  state_o;
  logic [13:0] delay_ms;

  // Driver of the player buttons; observer of the stimulus outputs.
  modport master (
    output start, stop, clear,
    input  stim_led, go, halt, early, timeout, state_o, delay_ms
  );

  // The reaction_stimulus controller itself.
  modport slave (
    input  start, stop, clear,
    output stim_led, go, halt, early, timeout, state_o, delay_ms
  );
endinterface

// File: rtl/reaction_stimulus.sv
// Reaction-time stimulus controller.
// After start, waits a pseudo-random number of milliseconds (derived from a
// free-running LFSR), lights the stimulus LED and pulses go, then waits for
// stop or a timeout and pulses halt. A stop before the LED lights is a cheat.
// state_o exposes the FSM state directly for observation.
module reaction_stimulus #(
  parameter int TICK_DIV   = 100000,
  parameter int MIN_MS     = 2000,
  parameter int STEP_MS    = 500,
  parameter int TIMEOUT_MS = 1000
) (
  input logic                clk,
  input logic                rst,
  reaction_stimulus_if.slave bus
);

  // State encoding is visible on state_o, so the values are fixed.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_CHEAT = 3'd4;

  // Prescaler width; TICK_DIV of 1 still needs a one-bit counter.
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]    MIN_W    = 14'(MIN_MS);
  localparam logic [13:0]    STEP_W   = 14'(STEP_MS);
  localparam logic [13:0]    TO_LAST  = 14'(TIMEOUT_MS - 1);
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shift form.
  localparam logic [15:0]    LFSR_SEED = 16'hACE1;
  localparam logic [15:0]    LFSR_TAPS = 16'hB400;

  logic [15:0]   lfsr_q, lfsr_d;
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   ms_cnt_q, ms_cnt_d;
  logic [13:0]   delay_q, delay_d;
  logic          stim_led_q, stim_led_d;
  logic          go_q, go_d;
  logic          halt_q, halt_d;
  logic          early_q, early_d;
  logic          timeout_q, timeout_d;

  logic          tick;
  logic          wait_done;
  logic          armed_expired;
  logic          timeout_event;

  // Millisecond tick on the last prescaler count; the phase ends on the
  // tick that completes the final millisecond of the programmed interval.
  assign tick          = (presc_q == PRE_LAST);
  assign wait_done     = tick && (ms_cnt_q == (delay_q - 14'd1));
  assign armed_expired = tick && (ms_cnt_q == TO_LAST);

  // LFSR advances every cycle regardless of state, so the delay chosen at
  // start depends on how long the player idled beforehand.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // Next state and delay latch; clear beats stop, stop beats start.
  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    timeout_event = 1'b0;
    if (bus.clear) begin
      state_d = S_IDLE;
      delay_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A coincident stop outranks start, and stop is a no-op here.
          if (bus.start && !bus.stop) begin
            state_d = S_WAIT;
            delay_d = MIN_W + 14'(lfsr_q[3:0]) * STEP_W;
          end
        end
        S_WAIT: begin
          if (bus.stop) begin
            state_d = S_CHEAT;
          end else if (wait_done) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          // Stop on the very tick that would time out still counts as stop.
          if (bus.stop) begin
            state_d = S_DONE;
          end else if (armed_expired) begin
            state_d       = S_DONE;
            timeout_event = 1'b1;
          end
        end
        S_DONE, S_CHEAT: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Prescaler and ms counter run only inside timed phases and restart on
  // every state change so each phase measures from its own entry.
  always_comb begin
    presc_d  = '0;
    ms_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_WAIT) || (state_q == S_ARMED))) begin
      if (tick) begin
        ms_cnt_d = ms_cnt_q + 14'd1;
      end else begin
        presc_d  = presc_q + PW'(1);
        ms_cnt_d = ms_cnt_q;
      end
    end
  end

  // Output registers are loaded from the upcoming state so they line up
  // with state_o; go and halt mark the entry edges of ARMED and DONE.
  always_comb begin
    stim_led_d = (state_d == S_ARMED);
    go_d       = (state_q == S_WAIT) && (state_d == S_ARMED);
    halt_d     = (state_q == S_ARMED) && (state_d == S_DONE);
    early_d    = (state_d == S_CHEAT);
    timeout_d  = 1'b0;
    if (state_d == S_DONE) begin
      timeout_d = (state_q == S_DONE) ? timeout_q : timeout_event;
    end
  end

  // State, counters and outputs; reset aborts any trial silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q     <= LFSR_SEED;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      ms_cnt_q   <= '0;
      delay_q    <= '0;
      stim_led_q <= 1'b0;
      go_q       <= 1'b0;
      halt_q     <= 1'b0;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_cnt_q   <= ms_cnt_d;
      delay_q    <= delay_d;
      stim_led_q <= stim_led_d;
      go_q       <= go_d;
      halt_q     <= halt_d;
      early_q    <= early_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.stim_led = stim_led_q;
  assign bus.go       = go_q;
  assign bus.halt     = halt_q;
  assign bus.early    = early_q;
  assign bus.timeout  = timeout_q;
  assign bus.state_o  = state_q;
  assign bus.delay_ms = delay_q;

endmodule
